// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop, then samples the device acknowledge. Pads are open-drain.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_50,
  input  logic       areset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [9:0]       clk_sr;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       bit_idx;
  logic [9:0]       frame;
  logic             fe_c;
  logic             timed_c;
  logic             lines_idle_c;
  logic             abort_c;

  // Debounced falling edge: five old samples high, five new samples low.
  assign fe_c         = (clk_sr[4:0] == 5'h1f) && (clk_sr[9:5] == 5'h00);
  assign timed_c      = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign lines_idle_c = ps2_clk && ps2_dat;
  // An edge always clears the watchdog, and a finished frame beats the abort.
  assign abort_c      = timed_c && !fe_c && (to_cnt == TO_LAST) &&
                        !((state == WAIT_IDLE) && lines_idle_c);

  always_ff @(posedge clk_50) begin
    if (areset) begin
      state      <= IDLE;
      clk_sr     <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
    end else begin
      clk_sr <= {ps2_clk, clk_sr[9:1]};
      done   <= 1'b0;
      error  <= 1'b0;

      if (abort_c) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        ack_ok     <= 1'b0;
        error      <= 1'b1;
        busy       <= 1'b0;
        to_cnt     <= '0;
        state      <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            tx_ready   <= 1'b1;
            if (tx_valid && tx_ready) begin
              frame      <= {1'b1, ~^tx_data, tx_data};
              ack_ok     <= 1'b0;
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= INHIBIT;
            end
          end

          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_dat_oe <= 1'b1;
              state      <= REQUEST;
            end else begin
              inh_cnt <= inh_cnt + INH_W'(1);
            end
          end

          // Start bit stays driven low; the device now owns the clock.
          REQUEST: begin
            ps2_clk_oe <= 1'b0;
            bit_idx    <= '0;
            to_cnt     <= '0;
            state      <= SEND;
          end

          SEND: begin
            if (fe_c) begin
              to_cnt     <= '0;
              ps2_dat_oe <= ~frame[bit_idx];
              bit_idx    <= bit_idx + 4'd1;
              if (bit_idx == 4'd9) begin
                state <= ACK;
              end
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          ACK: begin
            ps2_dat_oe <= 1'b0;
            if (fe_c) begin
              ack_ok <= ~ps2_dat;
              to_cnt <= '0;
              state  <= WAIT_IDLE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          WAIT_IDLE: begin
            if (lines_idle_c) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (fe_c) begin
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
